sram_1r1w_bypass: RTL and testbench

- Parametrised behavioural single-clock 1R1W SRAM with byte-lane write masks and a pipelined synchronous read of 1 or 2 cycles.
- Configurable read-during-write forwarding at the same address.
- Saturating counter of same-address read/write collisions.
- Hardware zero-fill (scrub) sequencer. Sits between the Wishbone/DMA fabric and local buffer storage; next generation of the fixed 32x2048 macro models.

---
 rtl/sram_1r1w_bypass.sv | 136 +++++++++++++
 tb/tb_sram_1r1w_bypass.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_bypass.sv
// Byte-masked 1R1W SRAM with same-address read forwarding, collision counter and zero-fill sequencer.
// Latency: read data READ_LATENCY (1|2) cycles after the request cycle; writes visible to the next read.
// Backpressure: none on the data path; rd_en/wr_en are dropped while busy (zero-fill) is high.
module sram_1r1w_bypass #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  parameter int COLL_W       = 8
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_mask,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    init_req,
  output logic                    busy,
  output logic [COLL_W-1:0]       coll_count
);
  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, INIT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  rd_acc, wr_acc, coll;
  logic [DATA_WIDTH-1:0] wr_merged, rd_word;

  assign busy   = (state == INIT);
  assign rd_acc = rd_en & ~busy;
  assign wr_acc = wr_en & ~busy;
  assign coll   = rd_acc & wr_acc & (rd_addr == wr_addr);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (init_req) begin
          state_nxt = INIT;
          ptr_nxt   = '0;
        end
      end
      INIT: begin
        ptr_nxt = ptr + 1'b1;
        if (&ptr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word after this cycle's write; doubles as the forwarded value on a collision.
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wr_mask[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_word = mem[rd_addr];
    if ((BYPASS != 0) && coll) rd_word = wr_merged;
  end

  // Array contents survive reset; scrub owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr] <= '0;
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  logic                  p1_vld;
  logic [DATA_WIDTH-1:0] p1_dat;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p1_vld <= 1'b0;
      p1_dat <= '0;
    end else begin
      p1_vld <= rd_acc;
      if (rd_acc) p1_dat <= rd_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  p2_vld;
      logic [DATA_WIDTH-1:0] p2_dat;

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          p2_vld <= 1'b0;
          p2_dat <= '0;
        end else begin
          p2_vld <= p1_vld;
          if (p1_vld) p2_dat <= p1_dat;
        end
      end

      assign rd_valid = p2_vld;
      assign rd_data  = p2_dat;
    end else begin : g_lat1
      assign rd_valid = p1_vld;
      assign rd_data  = p1_dat;
    end
  endgenerate

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      coll_count <= '0;
    end else if (coll && !(&coll_count)) begin
      coll_count <= coll_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_1r1w_bypass.sv
// Bench for sram_1r1w_bypass: instance a (latency 1, forwarding) and instance b (latency 2, no forwarding)
// share one stimulus stream and are checked each cycle against a reference memory model.
module tb_sram_1r1w_bypass;
  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk  = 1'b0;
  logic          nrst = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0, init_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [3:0]    wr_mask = '0;
  logic [31:0]   wr_data = '0;

  logic [31:0]   rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, busy_a, busy_b;
  logic [7:0]    coll_a, coll_b;

  always #5 clk = ~clk;

  sram_1r1w_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(1), .BYPASS(1), .COLL_W(8)) dut_a (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .init_req(init_req), .busy(busy_a), .coll_count(coll_a));

  sram_1r1w_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(2), .BYPASS(0), .COLL_W(8)) dut_b (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .init_req(init_req), .busy(busy_b), .coll_count(coll_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Reference model: plain array memory, scrub countdown, and per-instance schedule of
  // expected read returns keyed by the cycle they must appear in.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          m_left = 0, m_ptr = 0, m_coll = 0, cyc = 0;
  bit          slot_v [2][4];
  logic [31:0] slot_d [2][4];
  bit          slot_k [2][4];
  logic [31:0] last_d [2];
  bit          last_k [2];
  logic [31:0] t_old, t_rd;
  bit          t_ev;
  int          t_s, t_due;
  logic        t_av;
  logic [31:0] t_ad;

  always @(negedge clk) begin
    if (!nrst) begin
      m_left = 0;
      m_ptr  = 0;
      m_coll = 0;
      for (int i = 0; i < 2; i++) begin
        last_d[i] = '0;
        last_k[i] = 1'b1;
        for (int s = 0; s < 4; s++) slot_v[i][s] = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      t_s  = cyc % 4;
      t_ev = slot_v[i][t_s];
      if (t_ev) begin
        last_d[i] = slot_d[i][t_s];
        last_k[i] = slot_k[i][t_s];
        slot_v[i][t_s] = 1'b0;
      end
      t_av = (i == 0) ? rd_valid_a : rd_valid_b;
      t_ad = (i == 0) ? rd_data_a : rd_data_b;
      chk($sformatf("cyc%0d_rd_valid_%0d", cyc, i), 32'(t_av), 32'(t_ev));
      if (last_k[i]) chk($sformatf("cyc%0d_rd_data_%0d", cyc, i), t_ad, last_d[i]);
    end
    chk($sformatf("cyc%0d_busy_a", cyc), 32'(busy_a), 32'(m_left > 0));
    chk($sformatf("cyc%0d_busy_b", cyc), 32'(busy_b), 32'(m_left > 0));
    chk($sformatf("cyc%0d_coll_a", cyc), 32'(coll_a), m_coll);
    chk($sformatf("cyc%0d_coll_b", cyc), 32'(coll_b), m_coll);

    // Apply the coming clock edge using the inputs now stable on the bus.
    if (nrst) begin
      cyc = cyc + 1;
      if (m_left > 0) begin
        m_mem[m_ptr]   = '0;
        m_known[m_ptr] = 1'b1;
        m_ptr  = m_ptr + 1;
        m_left = m_left - 1;
      end else begin
        if (rd_en) begin
          t_old = m_mem[rd_addr];
          for (int i = 0; i < 2; i++) begin
            t_rd = t_old;
            if (i == 0 && wr_en && wr_addr == rd_addr) t_rd = merge(t_old, wr_data, wr_mask);
            t_due = cyc + i;
            slot_v[i][t_due % 4] = 1'b1;
            slot_d[i][t_due % 4] = t_rd;
            slot_k[i][t_due % 4] = m_known[rd_addr];
          end
          if (wr_en && wr_addr == rd_addr && m_coll < 255) m_coll = m_coll + 1;
        end
        if (wr_en) begin
          m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_mask);
          if (wr_mask == 4'hF) m_known[wr_addr] = 1'b1;
        end
        if (init_req) begin
          m_left = DEPTH;
          m_ptr  = 0;
        end
      end
    end
  end

  task automatic step(input logic r, input logic [AW-1:0] ra, input logic w, input logic [AW-1:0] wa,
                      input logic [3:0] m, input logic [31:0] d, input logic ini);
    rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_mask = m; wr_data = d; init_req = ini;
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0; init_req = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 4'h0, '0, 1'b0);
  endtask

  int n, v_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid_a", 32'(rd_valid_a), 32'd0);
    chk("reset_rd_data_a", rd_data_a, 32'd0);
    chk("reset_rd_data_b", rd_data_b, 32'd0);
    chk("reset_busy_a", 32'(busy_a), 32'd0);
    chk("reset_coll_a", 32'(coll_a), 32'd0);
    nrst = 1'b1;
    idle();

    step(1'b0, '0, 1'b1, 11'h005, 4'hF, 32'hDEADBEEF, 1'b0);
    step(1'b1, 11'h005, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("basic_valid_a", 32'(rd_valid_a), 32'd1);
    chk("basic_data_a", rd_data_a, 32'hDEADBEEF);
    chk("basic_valid_b_early", 32'(rd_valid_b), 32'd0);
    idle();
    chk("basic_valid_a_drop", 32'(rd_valid_a), 32'd0);
    chk("basic_data_a_hold", rd_data_a, 32'hDEADBEEF);
    chk("basic_data_b", rd_data_b, 32'hDEADBEEF);
    chk("basic_coll", 32'(coll_a), 32'd0);

    step(1'b0, '0, 1'b1, 11'h7FF, 4'hF, 32'h11223344, 1'b0);
    step(1'b0, '0, 1'b1, 11'h7FF, 4'b0101, 32'hAABBCCDD, 1'b0);
    step(1'b1, 11'h7FF, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("mask_merge_a", rd_data_a, 32'h11BB33DD);
    idle();
    chk("mask_merge_b", rd_data_b, 32'h11BB33DD);

    step(1'b0, '0, 1'b1, 11'h010, 4'hF, 32'h01020304, 1'b0);
    step(1'b1, 11'h010, 1'b1, 11'h010, 4'b1000, 32'hFFFFFFFF, 1'b0);
    chk("coll_bypass_a", rd_data_a, 32'hFF020304);
    chk("coll_count_1", 32'(coll_a), 32'd1);
    idle();
    chk("coll_nobypass_b", rd_data_b, 32'h01020304);
    chk("coll_count_1_b", 32'(coll_b), 32'd1);

    step(1'b0, '0, 1'b1, 11'd1, 4'hF, 32'hA1A1A1A1, 1'b0);
    step(1'b0, '0, 1'b1, 11'd2, 4'hF, 32'hB2B2B2B2, 1'b0);
    step(1'b0, '0, 1'b1, 11'd3, 4'hF, 32'hC3C3C3C3, 1'b0);
    step(1'b1, 11'd1, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("lat2_first_not_yet", 32'(rd_valid_b), 32'd0);
    step(1'b1, 11'd2, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("lat2_v1", 32'(rd_valid_b), 32'd1);
    chk("lat2_d1", rd_data_b, 32'hA1A1A1A1);
    step(1'b1, 11'd3, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("lat2_d2", rd_data_b, 32'hB2B2B2B2);
    idle();
    chk("lat2_v3", 32'(rd_valid_b), 32'd1);
    chk("lat2_d3", rd_data_b, 32'hC3C3C3C3);
    idle();
    chk("lat2_v_end", 32'(rd_valid_b), 32'd0);
    chk("lat2_hold", rd_data_b, 32'hC3C3C3C3);

    for (int i = 0; i < 300; i++) step(1'b1, 11'h020, 1'b1, 11'h020, 4'h0, 32'h0, 1'b0);
    chk("coll_sat_a", 32'(coll_a), 32'd255);
    chk("coll_sat_b", 32'(coll_b), 32'd255);

    step(1'b0, '0, 1'b1, 11'd0, 4'hF, 32'hA5A5A5A5, 1'b0);
    step(1'b0, '0, 1'b0, '0, 4'h0, '0, 1'b1);
    n = 0;
    v_seen = 0;
    while (busy_a && n < 3000) begin
      v_seen += int'(rd_valid_a) + int'(rd_valid_b);
      step(1'b1, 11'(n % 4), 1'b1, 11'd0, 4'hF, 32'h5A5A0000 | 32'(n), n == 5);
      n++;
    end
    chk("scrub_busy_cycles", 32'(n), 32'd2048);
    chk("scrub_no_rd_valid", 32'(v_seen), 32'd0);
    step(1'b1, 11'd0, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("scrub_addr0_valid", 32'(rd_valid_a), 32'd1);
    chk("scrub_addr0_zero", rd_data_a, 32'd0);
    step(1'b1, 11'd2047, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("scrub_addr2047_zero", rd_data_a, 32'd0);
    idle();
    chk("scrub_addr2047_zero_b", rd_data_b, 32'd0);

    step(1'b0, '0, 1'b1, 11'd1000, 4'hF, 32'hCAFEF00D, 1'b0);
    step(1'b0, '0, 1'b1, 11'd50, 4'hF, 32'h12345678, 1'b0);
    step(1'b1, 11'd1000, 1'b1, 11'd20, 4'hF, 32'h0, 1'b0);
    step(1'b1, 11'd1000, 1'b0, '0, 4'h0, '0, 1'b1);
    chk("init_edge_read_valid", 32'(rd_valid_a), 32'd1);
    chk("init_edge_read_data", rd_data_a, 32'hCAFEF00D);
    chk("init_edge_busy", 32'(busy_a), 32'd1);
    repeat (100) idle();
    nrst = 1'b0;
    #1;
    chk("async_rst_busy_a", 32'(busy_a), 32'd0);
    chk("async_rst_busy_b", 32'(busy_b), 32'd0);
    chk("async_rst_valid_b", 32'(rd_valid_b), 32'd0);
    chk("async_rst_coll_a", 32'(coll_a), 32'd0);
    chk("async_rst_coll_b", 32'(coll_b), 32'd0);
    chk("async_rst_data_a", rd_data_a, 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    idle();
    step(1'b1, 11'd50, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("partial_scrub_addr50", rd_data_a, 32'd0);
    step(1'b1, 11'd1000, 1'b0, '0, 4'h0, '0, 1'b0);
    chk("partial_scrub_addr1000", rd_data_a, 32'hCAFEF00D);
    chk("partial_scrub_addr50_b", rd_data_b, 32'd0);
    idle();
    chk("partial_scrub_addr1000_b", rd_data_b, 32'hCAFEF00D);
    repeat (3) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
